whack_scorer: RTL and testbench
===============================

Name: whack_scorer

Overview:
- Downstream consumer of mole_generator.
- Each rising edge of mole_clk opens a new round. On that edge the block latches the 18-bit mole_positions vector as the set of live moles.
- During a round it detects player whacks as toggles on the 18 board switches, and clears each whacked mole from the live set.
- It counts hits, wrong whacks and escaped moles, and drives the visible-mole LED vector plus game-over status to the display/score stages.

Parameters:
- N_HOLES, 18, number of holes; width of mole_positions, switches and LED vector.
- SCORE_W, 10, width of the hit/miss counters; counters saturate at 2^SCORE_W-1.
- MAX_ESCAPES, 20, escaped-mole total at which the game ends.

Ports:
- clk  in  1  system clock, same domain as mole_generator.
- reset  in  1  synchronous, active-high reset.
- game_enable  in  1  level; high = game running.
- mole_clk  in  1  round tick from the rate stage; 2-flop synchronized internally.
- mole_positions  in  N_HOLES  one-hot-ish mole vector from mole_generator (0–3 bits set).
- switches  in  N_HOLES  raw board switches; 2-flop synchronized internally.
- visible_moles  out  N_HOLES  live-mole mask to LEDs.
- hit_count  out  SCORE_W  moles whacked this game.
- miss_count  out  SCORE_W  wrong whacks (toggle on a hole with no live mole).
- escape_count  out  SCORE_W  moles still live when their round ended.
- hit_strobe  out  1  one-cycle pulse when at least one hit is registered.
- game_over  out  1  high in GAME_OVER state.

Behaviour:
- Reset (synchronous, active-high; priority over everything):
  - All outputs are 0 and FSM=IDLE.
  - Synchronizer and previous-value registers are 0.
- Synchronizers: sw_s1<=switches, sw_s2<=sw_s1, sw_prev<=sw_s2. mole_clk uses the identical chain.
- whack = sw_s2 ^ sw_prev. Both switch directions count as a whack.
- round_start = mc_s2 & ~mc_prev.
- Latency: a change first sampled at edge k produces whack/round_start during cycle k+1..k+2; its registered effect appears after edge k+2.
- FSM IDLE:
  - Whacks are ignored, and the synchronizer registers keep tracking, so switch positions at reset never score.
  - round_start with game_enable=1 → clear all three counters, load live mask from mole_positions, go ACTIVE.
- FSM ACTIVE, per cycle:
  - hits = whack & live.
  - wrong = whack & ~live.
  - live <= live & ~whack.
  - hit_count += popcount(hits).
  - miss_count += popcount(wrong).
  - hit_strobe <= |hits.
- FSM ACTIVE, on round_start:
  - escaped = popcount(live after this cycle's whacks); escape_count += escaped.
  - live <= mole_positions.
  - A whack in the same cycle is scored against the old mask first; it never clears a newly loaded mole.
- ACTIVE → GAME_OVER when the updated escape_count >= MAX_ESCAPES. In that case live is cleared instead of reloaded.
- Any state, game_enable=0 → IDLE; live cleared, counters hold their values for display.
- GAME_OVER:
  - game_over=1, visible_moles=0, all whacks ignored, counters hold.
  - Leaves only via game_enable=0 (→IDLE).
- Width rules:
  - Popcounts are 5 bits, zero-extended to SCORE_W before adding.
  - All additions saturate at 2^SCORE_W-1 and never wrap.
- visible_moles = registered live mask; hit_strobe is registered.
- Reset asserted mid-round: outputs are 0 the cycle after, and no partial tally is taken.

Decomposition:
- Shared package whack_pkg holds:
  - N_HOLES default, the state enum (IDLE, ACTIVE, GAME_OVER), SCORE_W default;
  - function popcount18;
  - function sat_add(SCORE_W acc, 5-bit inc).
- One natural sub-module: toggle_sync. It is a parameterized-width 2-flop synchronizer plus previous-value register. It outputs a toggle vector for the switches, and a rise pulse for mole_clk when width=1 and rise mode is selected.

Test Plan:
- Reset → visible_moles=0, all counts 0, game_over=0; switches=18'h3FFFF held through reset and first round → hit_count and miss_count stay 0 (IDLE ignores whacks).
- game_enable=1, mole_positions=18'h00005, mole_clk pulse → visible_moles=18'h00005 two cycles after sync; toggle SW0 → hit_count=1, hit_strobe one cycle, visible_moles=18'h00004.
- Same round, toggle SW5 (no mole) → miss_count=1, visible_moles unchanged.
- Next mole_clk rise with SW2 toggled the same cycle → hit counted on the old mask, escape_count=0, and the new mask loads intact.
- MAX_ESCAPES=3, three rounds each leaving one mole unwhacked → escape_count=3, game_over=1, visible_moles=0; later toggles change nothing; game_enable=0 → IDLE, counts held; next enabled round_start → counts cleared.
- SCORE_W=3, hit 9 moles → hit_count saturates at 7; reset asserted mid-round → all outputs 0 the next cycle.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole scorer: state encoding,
// an 18-bit population count and a saturating score adder.
package whack_pkg;

  localparam int N_HOLES_DEF = 18;
  localparam int SCORE_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAME_OVER
  } state_t;

  function automatic logic [4:0] popcount18(input logic [17:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 18; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Callers pass their counter zero-extended to 16 bits plus their own ceiling.
  function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [4:0] inc,
                                          input logic [15:0] max_val);
    logic [16:0] s;
    s = {1'b0, acc} + {12'b0, inc};
    if (s > {1'b0, max_val}) return max_val;
    return s[15:0];
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer plus previous-value register; emits either a toggle
// vector (any change) or a rising-edge pulse per bit.
module toggle_sync #(
  parameter int W    = 1,
  parameter bit RISE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] evt
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign evt = RISE ? (s2 & ~prev) : (s2 ^ prev);

endmodule

// File: rtl/whack_scorer.sv
// Round-based mole scorer: latches the live-mole mask on each mole_clk rise,
// scores switch toggles as hits or misses, and tallies escaped moles.
module whack_scorer
  import whack_pkg::*;
#(
  parameter int N_HOLES     = N_HOLES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int MAX_ESCAPES = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_enable,
  input  logic               mole_clk,
  input  logic [N_HOLES-1:0] mole_positions,
  input  logic [N_HOLES-1:0] switches,
  output logic [N_HOLES-1:0] visible_moles,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic [SCORE_W-1:0] escape_count,
  output logic               hit_strobe,
  output logic               game_over
);

  localparam logic [15:0] SAT_MAX = 16'((1 << SCORE_W) - 1);
  localparam logic [31:0] MAX_E   = 32'(MAX_ESCAPES);

  logic [N_HOLES-1:0] whack;
  logic               round_start;

  toggle_sync #(.W(N_HOLES), .RISE(1'b0)) u_sw_sync (
    .clk(clk), .reset(reset), .din(switches), .evt(whack)
  );

  toggle_sync #(.W(1), .RISE(1'b1)) u_mc_sync (
    .clk(clk), .reset(reset), .din(mole_clk), .evt(round_start)
  );

  state_t             state_q, state_d;
  logic [N_HOLES-1:0] live_q, live_d;
  logic [SCORE_W-1:0] hit_q, hit_d, miss_q, miss_d, esc_q, esc_d;
  logic               strobe_q, strobe_d;

  logic [N_HOLES-1:0] hits, wrong, live_after;
  logic [SCORE_W-1:0] hit_sum, miss_sum, esc_sum;

  assign hits       = whack & live_q;
  assign wrong      = whack & ~live_q;
  assign live_after = live_q & ~whack;
  assign hit_sum    = SCORE_W'(sat_add(16'(hit_q), popcount18(18'(hits)), SAT_MAX));
  assign miss_sum   = SCORE_W'(sat_add(16'(miss_q), popcount18(18'(wrong)), SAT_MAX));
  // Escapes are counted after this cycle's whacks have cleared their moles.
  assign esc_sum    = SCORE_W'(sat_add(16'(esc_q), popcount18(18'(live_after)), SAT_MAX));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    esc_d    = esc_q;
    strobe_d = 1'b0;
    if (!game_enable) begin
      state_d = IDLE;
      live_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (round_start) begin
            hit_d   = '0;
            miss_d  = '0;
            esc_d   = '0;
            live_d  = mole_positions;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          hit_d    = hit_sum;
          miss_d   = miss_sum;
          strobe_d = |hits;
          live_d   = live_after;
          if (round_start) begin
            esc_d = esc_sum;
            if (32'(esc_sum) >= MAX_E) begin
              state_d = GAME_OVER;
              live_d  = '0;
            end else begin
              live_d = mole_positions;
            end
          end
        end
        GAME_OVER: live_d = '0;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      esc_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      live_q   <= live_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      esc_q    <= esc_d;
      strobe_q <= strobe_d;
    end
  end

  assign visible_moles = live_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign escape_count  = esc_q;
  assign hit_strobe    = strobe_q;
  assign game_over     = (state_q == GAME_OVER);

endmodule

// File: tb/tb_whack_scorer.sv
// Scoreboard bench for whack_scorer built with a 3-bit score width and a
// three-escape game limit so saturation and game-over are both reachable.
module tb_whack_scorer;

  localparam int NH = 18;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          game_enable;
  logic          mole_clk;
  logic [NH-1:0] mole_positions;
  logic [NH-1:0] switches;
  logic [NH-1:0] visible_moles;
  logic [SW-1:0] hit_count, miss_count, escape_count;
  logic          hit_strobe;
  logic          game_over;

  whack_scorer #(.N_HOLES(NH), .SCORE_W(SW), .MAX_ESCAPES(3)) dut (
    .clk(clk), .reset(reset), .game_enable(game_enable), .mole_clk(mole_clk),
    .mole_positions(mole_positions), .switches(switches),
    .visible_moles(visible_moles), .hit_count(hit_count), .miss_count(miss_count),
    .escape_count(escape_count), .hit_strobe(hit_strobe), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NH-1:0] vis;
    logic [SW-1:0] hit;
    logic [SW-1:0] miss;
    logic [SW-1:0] esc;
    logic          go;
  } exp_t;

  exp_t snap_q[$];
  exp_t strobe_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [NH-1:0] v, input int h, input int m,
                              input int e, input logic g);
    exp_t x;
    x.vis  = v;
    x.hit  = SW'(h);
    x.miss = SW'(m);
    x.esc  = SW'(e);
    x.go   = g;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares a snapshot whenever one is pending, and every hit_strobe
  // pulse against the next expected strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        cmp("visible_moles", 32'(visible_moles), 32'(e.vis));
        cmp("hit_count", 32'(hit_count), 32'(e.hit));
        cmp("miss_count", 32'(miss_count), 32'(e.miss));
        cmp("escape_count", 32'(escape_count), 32'(e.esc));
        cmp("game_over", 32'(game_over), 32'(e.go));
      end
      if (hit_strobe === 1'b1) begin
        if (strobe_q.size() == 0) begin
          cmp("unexpected_hit_strobe", 32'(1), 32'(0));
        end else begin
          e = strobe_q.pop_front();
          cmp("strobe_hit_count", 32'(hit_count), 32'(e.hit));
          cmp("strobe_visible", 32'(visible_moles), 32'(e.vis));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge; the monitor samples at the following posedge.
  task automatic snap(input exp_t e);
    snap_q.push_back(e);
    cyc(1);
  endtask

  task automatic toggle(input logic [NH-1:0] m);
    switches = switches ^ m;
    cyc(5);
  endtask

  task automatic round(input logic [NH-1:0] mp, input logic [NH-1:0] tog);
    mole_positions = mp;
    mole_clk       = 1'b1;
    switches       = switches ^ tog;
    cyc(3);
    mole_clk = 1'b0;
    cyc(4);
  endtask

  initial begin
    reset          = 1'b1;
    game_enable    = 1'b0;
    mole_clk       = 1'b0;
    mole_positions = '0;
    switches       = 18'h3FFFF;
    cyc(3);
    snap(mk(18'h0, 0, 0, 0, 1'b0));
    reset = 1'b0;
    cyc(6);
    snap(mk(18'h0, 0, 0, 0, 1'b0));

    game_enable = 1'b1;
    round(18'h00005, 18'h0);
    snap(mk(18'h00005, 0, 0, 0, 1'b0));

    strobe_q.push_back(mk(18'h00004, 1, 0, 0, 1'b0));
    toggle(18'h00001);
    snap(mk(18'h00004, 1, 0, 0, 1'b0));

    toggle(18'h00020);
    snap(mk(18'h00004, 1, 1, 0, 1'b0));

    // Whack on SW2 coincides with the round edge; new mask also has bit 2.
    strobe_q.push_back(mk(18'h00304, 2, 1, 0, 1'b0));
    round(18'h00304, 18'h00004);
    snap(mk(18'h00304, 2, 1, 0, 1'b0));

    strobe_q.push_back(mk(18'h00004, 4, 1, 0, 1'b0));
    toggle(18'h00300);
    snap(mk(18'h00004, 4, 1, 0, 1'b0));

    round(18'h00400, 18'h0);
    snap(mk(18'h00400, 4, 1, 1, 1'b0));
    round(18'h00800, 18'h0);
    snap(mk(18'h00800, 4, 1, 2, 1'b0));
    round(18'h01000, 18'h0);
    snap(mk(18'h0, 4, 1, 3, 1'b1));

    toggle(18'h01001);
    round(18'h00003, 18'h0);
    snap(mk(18'h0, 4, 1, 3, 1'b1));

    game_enable = 1'b0;
    cyc(3);
    snap(mk(18'h0, 4, 1, 3, 1'b0));

    game_enable = 1'b1;
    round(18'h001FF, 18'h0);
    snap(mk(18'h001FF, 0, 0, 0, 1'b0));

    strobe_q.push_back(mk(18'h001F0, 4, 0, 0, 1'b0));
    toggle(18'h0000F);
    strobe_q.push_back(mk(18'h0, 7, 0, 0, 1'b0));
    toggle(18'h001F0);
    snap(mk(18'h0, 7, 0, 0, 1'b0));

    round(18'h00003, 18'h0);
    snap(mk(18'h00003, 7, 0, 0, 1'b0));

    // Reset lands together with a pending whack: nothing may survive it.
    reset    = 1'b1;
    switches = switches ^ 18'h00001;
    snap(mk(18'h0, 0, 0, 0, 1'b0));
    cyc(4);
    reset = 1'b0;
    cyc(5);
    snap(mk(18'h0, 0, 0, 0, 1'b0));
    cyc(2);

    cmp("strobes_outstanding", 32'(strobe_q.size()), 32'(0));
    cmp("snapshots_outstanding", 32'(snap_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
